// File: rtl/bus_pkg.sv
// Shared types and address map for the two-master peripheral bus arbiter.
// Constants mirror the existing address decoder so both agree on every region.
package bus_pkg;

  typedef enum logic [2:0] {
    MEM,
    TC,
    UART,
    GPIO,
    PWM,
    NONE
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MEM_SIZE    = 32'h0000_2000;
  localparam logic [31:0] TC_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] UART_BASE   = 32'hFFFF_1000;
  localparam logic [31:0] GPIO_BASE   = 32'hFFFF_2000;
  localparam logic [31:0] PWM_BASE    = 32'hFFFF_3000;
  localparam logic [31:0] PERIPH_SIZE = 32'h0000_1000;

  // Reserved hole: driving it while idle guarantees no chip select fires.
  localparam logic [31:0] IDLE_ADDR   = 32'h8000_0000;

  // Regions are power-of-two sized and naturally aligned.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == base;
  endfunction

endpackage

// File: rtl/bus_region_lookup.sv
// Combinational address-to-region decode returning the region and its wait-state count.
// Unmapped addresses report NONE with a zero count.
module bus_region_lookup
  import bus_pkg::*;
#(
  parameter int unsigned MEM_WS  = 0,
  parameter int unsigned TC_WS   = 1,
  parameter int unsigned UART_WS = 2,
  parameter int unsigned GPIO_WS = 1,
  parameter int unsigned PWM_WS  = 1,
  parameter int unsigned WS_W    = 4
) (
  input  logic [31:0]     addr,
  output region_e         region,
  output logic [WS_W-1:0] ws
);

  always_comb begin
    region = NONE;
    ws     = '0;
    if (in_region(addr, MEM_BASE, MEM_SIZE)) begin
      region = MEM;
      ws     = WS_W'(MEM_WS);
    end else if (in_region(addr, TC_BASE, PERIPH_SIZE)) begin
      region = TC;
      ws     = WS_W'(TC_WS);
    end else if (in_region(addr, UART_BASE, PERIPH_SIZE)) begin
      region = UART;
      ws     = WS_W'(UART_WS);
    end else if (in_region(addr, GPIO_BASE, PERIPH_SIZE)) begin
      region = GPIO;
      ws     = WS_W'(GPIO_WS);
    end else if (in_region(addr, PWM_BASE, PERIPH_SIZE)) begin
      region = PWM;
      ws     = WS_W'(PWM_WS);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter and access sequencer for the shared peripheral bus.
// Latency req->ack is WS+2 (unmapped: 1); masters hold req until ack, all outputs registered.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MEM_WS  = 0,
  parameter int unsigned TC_WS   = 1,
  parameter int unsigned UART_WS = 2,
  parameter int unsigned GPIO_WS = 1,
  parameter int unsigned PWM_WS  = 1,
  parameter int unsigned WS_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_busy
);

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [WS_W-1:0] cnt_q, cnt_d;

  logic            m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic            m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [31:0]     m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            bus_we_q, bus_we_d;
  logic            bus_busy_q, bus_busy_d;

  logic            sel;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_we;
  region_e         sel_region;
  logic [WS_W-1:0] sel_ws;

  // On a tie the master not granted last wins; otherwise whoever is requesting.
  always_comb begin
    if (m0_req && m1_req) begin
      sel = ~last_grant_q;
    end else begin
      sel = m1_req;
    end
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    sel_we    = sel ? m1_we    : m0_we;
  end

  bus_region_lookup #(
    .MEM_WS  (MEM_WS),
    .TC_WS   (TC_WS),
    .UART_WS (UART_WS),
    .GPIO_WS (GPIO_WS),
    .PWM_WS  (PWM_WS),
    .WS_W    (WS_W)
  ) u_lookup (
    .addr   (sel_addr),
    .region (sel_region),
    .ws     (sel_ws)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = '0;
    m1_rdata_d   = '0;
    bus_addr_d   = IDLE_ADDR;
    bus_wdata_d  = '0;
    bus_we_d     = 1'b0;
    bus_busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d        = sel;
          last_grant_d = sel;
          we_d         = sel_we;
          if (sel_region == NONE) begin
            state_d  = DONE;
            m0_ack_d = ~sel;
            m0_err_d = ~sel;
            m1_ack_d = sel;
            m1_err_d = sel;
          end else begin
            state_d     = ACCESS;
            cnt_d       = sel_ws;
            bus_busy_d  = 1'b1;
            bus_addr_d  = sel_addr;
            bus_wdata_d = sel_wdata;
            bus_we_d    = sel_we && (sel_ws == '0);
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          m0_ack_d   = ~gnt_q;
          m1_ack_d   = gnt_q;
          m0_rdata_d = (!gnt_q && !we_q) ? bus_rdata : '0;
          m1_rdata_d = ( gnt_q && !we_q) ? bus_rdata : '0;
        end else begin
          // Strobe is registered, so raise it one cycle ahead of the final count.
          cnt_d       = cnt_q - WS_W'(1);
          bus_busy_d  = 1'b1;
          bus_addr_d  = bus_addr_q;
          bus_wdata_d = bus_wdata_q;
          bus_we_d    = we_q && (cnt_q == WS_W'(1));
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      bus_addr_q   <= IDLE_ADDR;
      bus_wdata_q  <= '0;
      bus_we_q     <= 1'b0;
      bus_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_we_q     <= bus_we_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: per-master drivers push expected responses; a monitor pops them on ack
// and checks data, bus sequencing, grant timing and round-robin against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int MEM_WS  = 0;
  localparam int TC_WS   = 1;
  localparam int UART_WS = 2;
  localparam int GPIO_WS = 1;
  localparam int PWM_WS  = 1;
  localparam int WS_W    = 4;
  localparam logic [31:0] IDLE_A = 32'h8000_0000;
  localparam int MAXC    = 8192;
  localparam int BUDGET  = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_busy;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MEM_WS(MEM_WS), .TC_WS(TC_WS), .UART_WS(UART_WS),
    .GPIO_WS(GPIO_WS), .PWM_WS(PWM_WS), .WS_W(WS_W)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_busy(bus_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          gap;
    bit          drop;
  } stim_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          ws;
  } exp_t;

  stim_t       s0_q[$], s1_q[$];
  exp_t        e0_q[$], e1_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [1:0]  req_hist [MAXC];
  int          earliest = 0;
  int          last_winner = 1;
  int          win_log[$];
  int          ack_cnt [2] = '{0, 0};
  int          run_len = 0;
  logic [31:0] run_addr, run_wdata;
  bit          run_stable;
  int          we_cnt = 0;
  int          we_idx = -1;

  // Wait states by address map; -1 means unmapped.
  function automatic int ref_ws(input logic [31:0] a);
    if (a < 32'h0000_2000) return MEM_WS;
    case (a >> 12)
      32'h000F_FFF0: return TC_WS;
      32'h000F_FFF1: return UART_WS;
      32'h000F_FFF2: return GPIO_WS;
      32'h000F_FFF3: return PWM_WS;
      default:       return -1;
    endcase
  endfunction

  function automatic logic [31:0] periph(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] holes [4];
    holes[0] = 32'h0000_2000;
    holes[1] = 32'hFFFF_4000;
    holes[2] = 32'h1234_0000;
    holes[3] = 32'h8000_0000;
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 32'h1FFF));
      1:       return 32'hFFFF_0000 | ($urandom & 32'hFFF);
      2:       return 32'hFFFF_1000 | ($urandom & 32'hFFF);
      3:       return 32'hFFFF_2000 | ($urandom & 32'hFFF);
      4:       return 32'hFFFF_3000 | ($urandom & 32'hFFF);
      default: return holes[$urandom_range(0, 3)] | ($urandom & 32'hFFC);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_m(input int m, input logic r, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    if (m == 0) begin
      m0_req = r; m0_addr = a; m0_we = w; m0_wdata = d;
    end else begin
      m1_req = r; m1_addr = a; m1_we = w; m1_wdata = d;
    end
  endtask

  task automatic drive(input int m);
    stim_t s;
    exp_t  e;
    int    waited;
    bit    got;
    forever begin
      if (m == 0) begin
        if (s0_q.size() == 0) break;
        s = s0_q.pop_front();
      end else begin
        if (s1_q.size() == 0) break;
        s = s1_q.pop_front();
      end
      for (int g = 0; g < s.gap; g++) begin
        set_m(m, 1'b0, '0, 1'b0, '0);
        tick(1);
      end
      e.addr  = s.addr;
      e.we    = s.we;
      e.wdata = s.wdata;
      e.ws    = ref_ws(s.addr);
      e.err   = (e.ws < 0);
      e.rdata = (e.err || s.we) ? 32'h0 : periph(s.addr);
      e.lat   = e.err ? 1 : e.ws + 2;
      if (m == 0) e0_q.push_back(e); else e1_q.push_back(e);
      set_m(m, 1'b1, s.addr, s.we, s.wdata);
      waited = 0;
      got    = 0;
      while (!got && waited < BUDGET) begin
        tick(1);
        waited++;
        if (s.drop && waited == 1) set_m(m, 1'b0, s.addr, s.we, s.wdata);
        if ((m == 0) ? m0_ack : m1_ack) got = 1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL ack_timeout: master %0d no ack within %0d cycles for addr %h", m, BUDGET, s.addr);
      end
    end
    set_m(m, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic process_ack(input int m, input logic err, input logic [31:0] rdata);
    exp_t e;
    int   g;
    bit   ok;
    if ((m == 0) ? (e0_q.size() == 0) : (e1_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: master %0d acked with nothing outstanding (cycle %0d)", m, cyc);
    end else begin
      e = (m == 0) ? e0_q.pop_front() : e1_q.pop_front();
      chk("resp_err", 32'(err), 32'(e.err));
      chk("resp_rdata", rdata, e.rdata);
      if (!e.err) begin
        chk("busy_len", 32'(run_len), 32'(e.ws + 1));
        chk("bus_addr_held", 32'(run_stable && run_addr == e.addr), 32'd1);
        chk("bus_wdata_held", run_wdata, e.wdata);
        chk("we_count", 32'(we_cnt), e.we ? 32'd1 : 32'd0);
        if (e.we) chk("we_cycle", 32'(we_idx), 32'(e.ws));
      end else begin
        chk("err_no_busy", 32'(run_len), 32'd0);
        chk("err_no_we", 32'(we_cnt), 32'd0);
      end
      g  = cyc - e.lat;
      ok = (g >= earliest) && (g >= 0) && (g < MAXC);
      if (ok) ok = req_hist[g][m];
      if (ok) for (int c = earliest; c < g; c++) if (req_hist[c] != 2'b00) ok = 0;
      chk("grant_time", 32'(ok), 32'd1);
      if (g >= 0 && g < MAXC && req_hist[g][1-m]) chk("round_robin", 32'(m), 32'(1 - last_winner));
      last_winner = m;
      win_log.push_back(m);
      ack_cnt[m]++;
    end
    earliest = cyc + 1;
    run_len  = 0;
    we_cnt   = 0;
    we_idx   = -1;
  endtask

  // Monitor / peripheral model: samples 1ns after each edge.
  initial begin
    int w;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc - 1 < MAXC) req_hist[cyc-1] = {m1_req, m0_req};
      if (reset) begin
        earliest    = cyc;
        last_winner = 1;
        e0_q.delete();
        e1_q.delete();
        run_len   = 0;
        we_cnt    = 0;
        we_idx    = -1;
        bus_rdata = '0;
      end else begin
        if (bus_busy) begin
          if (run_len == 0) begin
            run_addr   = bus_addr;
            run_wdata  = bus_wdata;
            run_stable = 1;
          end else if (bus_addr != run_addr || bus_wdata != run_wdata) begin
            run_stable = 0;
          end
          if (bus_we) begin
            we_cnt++;
            we_idx = run_len;
          end
          run_len++;
          w = ref_ws(bus_addr);
          // Data is only valid in the final access cycle.
          bus_rdata = (w == run_len - 1) ? periph(bus_addr) : ~periph(bus_addr);
        end else begin
          chk("idle_bus_addr", bus_addr, IDLE_A);
          chk("idle_bus_we_wdata", bus_wdata | 32'(bus_we), 32'h0);
          bus_rdata = $urandom;
        end
        chk("one_ack_at_a_time", 32'(m0_ack & m1_ack), 32'd0);
        if (m0_ack) process_ack(0, m0_err, m0_rdata);
        else chk("m0_quiet", m0_rdata | 32'(m0_err), 32'h0);
        if (m1_ack) process_ack(1, m1_err, m1_rdata);
        else chk("m1_quiet", m1_rdata | 32'(m1_err), 32'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    int waited;
    reset = 1'b1;
    set_m(0, 1'b0, '0, 1'b0, '0);
    set_m(1, 1'b0, '0, 1'b0, '0);
    bus_rdata = '0;
    tick(3);

    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_m0_err", 32'(m0_err), 32'd0);
    chk("rst_m1_err", 32'(m1_err), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_busy", 32'(bus_busy), 32'd0);
    chk("rst_bus_addr", bus_addr, IDLE_A);
    chk("rst_bus_wdata", bus_wdata, 32'h0);

    // Tie at first IDLE, both keep requesting: grants must go 0,1,0,1.
    win_log.delete();
    s0_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 0, 1'b0});
    s0_q.push_back('{32'h0000_1FFC, 1'b1, 32'h1111_2222, 0, 1'b0});
    s1_q.push_back('{32'hFFFF_1004, 1'b1, 32'h0000_005A, 0, 1'b0});
    s1_q.push_back('{32'hFFFF_2008, 1'b0, 32'h0, 0, 1'b0});
    reset = 1'b0;
    fork
      drive(0);
      drive(1);
    join
    tick(3);
    chk("tie_grant_count", 32'(win_log.size()), 32'd4);
    for (int i = 0; i < win_log.size() && i < 4; i++) chk("alternate", 32'(win_log[i]), 32'(i % 2));

    // Unmapped read.
    s0_q.push_back('{32'h1234_0000, 1'b0, 32'h0, 0, 1'b0});
    drive(0);
    tick(2);

    // Request dropped after grant on a timer read.
    n = ack_cnt[0];
    s0_q.push_back('{32'hFFFF_0010, 1'b0, 32'h0, 0, 1'b1});
    drive(0);
    tick(10);
    chk("drop_single_ack", 32'(ack_cnt[0]), 32'(n + 1));
    chk("drop_no_restart", 32'(bus_busy), 32'd0);

    // Randomised traffic from both masters.
    for (int i = 0; i < 25; i++) begin
      s0_q.push_back('{rand_addr(), 1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3)), 1'b0});
      s1_q.push_back('{rand_addr(), 1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3)), 1'b0});
    end
    fork
      drive(0);
      drive(1);
    join
    tick(5);

    // Reset in the second ACCESS cycle of a UART write.
    n = ack_cnt[1];
    set_m(1, 1'b1, 32'hFFFF_1004, 1'b1, 32'h0000_00A5);
    waited = 0;
    while (!bus_busy && waited < 20) begin
      tick(1);
      waited++;
    end
    chk("rst_test_busy_seen", 32'(bus_busy), 32'd1);
    tick(1);
    chk("rst_test_we_before_final", 32'(bus_we), 32'd0);
    reset = 1'b1;
    set_m(1, 1'b0, '0, 1'b0, '0);
    tick(1);
    chk("rst_test_busy", 32'(bus_busy), 32'd0);
    chk("rst_test_ack", 32'(m1_ack), 32'd0);
    chk("rst_test_we", 32'(bus_we), 32'd0);
    chk("rst_test_addr", bus_addr, IDLE_A);
    reset = 1'b0;
    tick(8);
    chk("rst_test_no_ack", 32'(ack_cnt[1]), 32'(n));

    // After reset master 0 wins the first tie again.
    win_log.delete();
    s0_q.push_back('{32'hFFFF_3000, 1'b0, 32'h0, 0, 1'b0});
    s1_q.push_back('{32'h0000_0040, 1'b1, 32'hCAFE_F00D, 0, 1'b0});
    fork
      drive(0);
      drive(1);
    join
    tick(3);
    chk("post_rst_first_winner", (win_log.size() > 0) ? 32'(win_log[0]) : 32'hFFFF_FFFF, 32'd0);

    chk("queues_drained", 32'(e0_q.size() + e1_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
